// File: rtl/dmem_ctrl_pkg.sv
// Shared types and defaults for the data-memory access controller.
package dmem_ctrl_pkg;

    localparam int STATE_W       = 2;
    localparam int CNT_W         = 4;
    localparam int DEF_AB        = 11;
    localparam int DEF_DB        = 16;
    localparam int DEF_RD_LAT    = 1;
    localparam int DEF_MEM_WORDS = 2048;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// CPU request/response channel plus memory pin bundle of the access controller.
// slave  : the controller's view
// master : the environment's view (datapath and memory)
import dmem_ctrl_pkg::*;

interface dmem_access_ctrl_if #(
    parameter int AB = DEF_AB,
    parameter int DB = DEF_DB
);
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AB-1:0] req_addr;
    logic [DB-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DB-1:0] rsp_rdata;
    logic          rsp_err;
    logic          mem_rd;
    logic          mem_wr;
    logic [AB-1:0] mem_addr;
    logic [DB-1:0] mem_wdata;
    logic [DB-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_rd, mem_wr, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_rd, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_access_ctrl_lat_cnt.sv
// Loadable 4-bit down-counter with zero flag; times the read strobe.
import dmem_ctrl_pkg::*;

module dmem_lat_cnt (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/dmem_access_ctrl.sv
// Single-word load/store initiator for the asynchronous data memory.
// Optional out-of-range checking is enabled with `define DMEM_CTRL_BOUNDS_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | ready for a request, strobes low
// ST_WRITE | mem_wr high for one cycle (low if the store is dropped)
// ST_READ  | mem_rd high, latency counter running
// ST_RESP  | rsp_valid high, waiting for rsp_ready
import dmem_ctrl_pkg::*;

module dmem_access_ctrl #(
    parameter int AB        = DEF_AB,
    parameter int DB        = DEF_DB,
    parameter int RD_LAT    = DEF_RD_LAT,
    parameter int MEM_WORDS = DEF_MEM_WORDS
) (
    input  logic            clk,
    input  logic            rst_n,
    dmem_access_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(RD_LAT - 1);

    if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
        $error("dmem_access_ctrl: RD_LAT must be 1..15");
    end
    if (MEM_WORDS < 1 || MEM_WORDS > (1 << AB)) begin : g_bad_mem_words
        $error("dmem_access_ctrl: MEM_WORDS must fit the address width");
    end

    state_t        state, state_nxt;
    logic          ready_q;
    logic          rd_q;
    logic          wr_q;
    logic [AB-1:0] addr_q;
    logic [DB-1:0] wdata_q;
    logic [DB-1:0] rdata_q;
    logic          accept;
    logic          in_range;
    logic          cnt_zero;
    logic          cnt_load;
    logic          cnt_dec;

    assign accept = (state == ST_IDLE) && ready_q && bus.req_valid;

`ifdef DMEM_CTRL_BOUNDS_EN
    logic err_q;

    assign in_range    = (32'(bus.req_addr) < 32'(MEM_WORDS));
    assign bus.rsp_err = err_q;

    // Error flag: set by an out-of-range load, cleared by its response handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (accept && !bus.req_we && !in_range) begin
            err_q <= 1'b1;
        end else if ((state == ST_RESP) && bus.rsp_ready) begin
            err_q <= 1'b0;
        end
    end
`else
    assign in_range    = 1'b1;
    assign bus.rsp_err = 1'b0;
`endif

    assign cnt_load = accept && !bus.req_we;
    assign cnt_dec  = (state == ST_READ) && !cnt_zero;

    dmem_lat_cnt u_lat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (LAT_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; an out-of-range load skips the read phase.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (bus.req_we)    state_nxt = ST_WRITE;
                    else if (in_range) state_nxt = ST_READ;
                    else               state_nxt = ST_RESP;
                end
            end
            ST_WRITE: state_nxt = ST_IDLE;
            ST_READ:  if (cnt_zero) state_nxt = ST_RESP;
            ST_RESP:  if (bus.rsp_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Registered pins: strobes, address/data hold, read capture and ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            ready_q <= (state_nxt == ST_IDLE);
            if (accept) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                wr_q    <= bus.req_we && in_range;
                rd_q    <= !bus.req_we && in_range;
                if (!bus.req_we && !in_range) begin
                    rdata_q <= '0;
                end
            end else begin
                wr_q <= 1'b0;
                if ((state == ST_READ) && cnt_zero) begin
                    rd_q    <= 1'b0;
                    rdata_q <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.mem_rd    = rd_q;
    assign bus.mem_wr    = wr_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: transaction-timing model plus directed vectors.
// Optional bounds tests follow `define DMEM_CTRL_BOUNDS_EN.
`timescale 1ns/1ps
module tb_dmem_access_ctrl;
    import dmem_ctrl_pkg::*;

    localparam int AB  = 11;
    localparam int DB  = 16;
    localparam int LAT = 3;
`ifdef DMEM_CTRL_BOUNDS_EN
    localparam int MW     = 1024;
    localparam bit BOUNDS = 1'b1;
`else
    localparam int MW     = 2048;
    localparam bit BOUNDS = 1'b0;
`endif
    localparam int INF = 32'h7fff_ffff;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_access_ctrl_if #(.AB(AB), .DB(DB)) bm ();
    dmem_access_ctrl_if #(.AB(AB), .DB(DB)) b1 ();

    dmem_access_ctrl #(.AB(AB), .DB(DB), .RD_LAT(LAT), .MEM_WORDS(MW)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bm.slave));
    dmem_access_ctrl #(.AB(AB), .DB(DB), .RD_LAT(1), .MEM_WORDS(MW)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave));

    // memory behaviour: word i preloaded with i, written on mem_wr
    logic [DB-1:0] mem [0:2047];
    bit mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 16'(i);
            mem_init <= 1'b1;
        end else if (bm.mem_wr) begin
            mem[bm.mem_addr] <= bm.mem_wdata;
        end
    end
    assign bm.mem_rdata = mem[bm.mem_addr];
    assign b1.mem_rdata = mem[b1.mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- transaction model ----------------
    typedef enum {K_NONE, K_ST, K_LD} kind_e;
    kind_e         m_kind = K_NONE;
    int            m_tacc, m_ready_from, m_rsp_from;
    bit            m_rsp_open, m_inr, m_need_rel;
    logic [AB-1:0] m_addr;
    logic [DB-1:0] m_wdata, m_rdata;
    bit            sh_w [0:2047];
    logic [DB-1:0] sh_v [0:2047];

    function automatic bit in_rng(input logic [AB-1:0] a);
        return !BOUNDS || (int'(a) < MW);
    endfunction

    function automatic logic [DB-1:0] sh_rd(input logic [AB-1:0] a);
        return sh_w[a] ? sh_v[a] : 16'(a);
    endfunction

    // accept at edge ending T: store strobes T+1, ready T+2; load strobes
    // T+1..T+LAT, response from T+LAT+1 (T+1 if out of range) until handshake
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_kind       <= K_NONE;
            m_rsp_open   <= 1'b0;
            m_ready_from <= INF;
            m_need_rel   <= 1'b1;
        end else if (m_need_rel) begin
            m_need_rel   <= 1'b0;
            m_ready_from <= cyc + 1;
        end else if (cyc >= m_ready_from && bm.req_valid) begin
            m_tacc  <= cyc;
            m_addr  <= bm.req_addr;
            m_wdata <= bm.req_wdata;
            m_inr   <= in_rng(bm.req_addr);
            if (bm.req_we) begin
                m_kind       <= K_ST;
                m_ready_from <= cyc + 2;
                if (in_rng(bm.req_addr)) begin
                    sh_w[bm.req_addr] <= 1'b1;
                    sh_v[bm.req_addr] <= bm.req_wdata;
                end
            end else begin
                m_kind       <= K_LD;
                m_ready_from <= INF;
                m_rsp_open   <= 1'b1;
                m_rsp_from   <= in_rng(bm.req_addr) ? cyc + LAT + 1 : cyc + 1;
                m_rdata      <= in_rng(bm.req_addr) ? sh_rd(bm.req_addr) : '0;
            end
        end else if (m_rsp_open && cyc >= m_rsp_from && bm.rsp_ready) begin
            m_rsp_open   <= 1'b0;
            m_ready_from <= cyc + 1;
        end
    end

    bit e_ready, e_wr, e_rd, e_rv, e_err;

    // compare DUT against model every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            if (!rst_n) begin
                chk("rst_req_ready", bm.req_ready, 0);
                chk("rst_rsp_valid", bm.rsp_valid, 0);
                chk("rst_rsp_rdata", bm.rsp_rdata, 0);
                chk("rst_rsp_err",   bm.rsp_err, 0);
                chk("rst_mem_rd",    bm.mem_rd, 0);
                chk("rst_mem_wr",    bm.mem_wr, 0);
                chk("rst_mem_addr",  bm.mem_addr, 0);
                chk("rst_mem_wdata", bm.mem_wdata, 0);
            end else begin
                e_ready = (cyc >= m_ready_from);
                e_wr    = (m_kind == K_ST) && m_inr && (cyc == m_tacc + 1);
                e_rd    = (m_kind == K_LD) && m_inr && (cyc >= m_tacc + 1) && (cyc <= m_tacc + LAT);
                e_rv    = m_rsp_open && (cyc >= m_rsp_from);
                e_err   = e_rv && !m_inr;
                chk("req_ready", bm.req_ready, e_ready);
                chk("mem_wr",    bm.mem_wr, e_wr);
                chk("mem_rd",    bm.mem_rd, e_rd);
                chk("rsp_valid", bm.rsp_valid, e_rv);
                chk("rsp_err",   bm.rsp_err, e_err);
                chk("strobe_excl", bm.mem_rd & bm.mem_wr, 0);
                if (e_rv) chk("rsp_rdata", bm.rsp_rdata, m_rdata);
                if (m_kind == K_NONE) begin
                    chk("idle_mem_addr",  bm.mem_addr, 0);
                    chk("idle_mem_wdata", bm.mem_wdata, 0);
                    chk("idle_rsp_rdata", bm.rsp_rdata, 0);
                end else begin
                    chk("mem_addr",  bm.mem_addr, m_addr);
                    chk("mem_wdata", bm.mem_wdata, m_wdata);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic req_m(input bit we, input logic [AB-1:0] a, input logic [DB-1:0] d, output int t);
        @(negedge clk);
        bm.req_valid = 1'b1;
        bm.req_we    = we;
        bm.req_addr  = a;
        bm.req_wdata = d;
        for (int i = 0; i < 50 && !bm.req_ready; i++) @(negedge clk);
        chk("req_accept", bm.req_ready, 1);
        t = cyc;
        @(negedge clk);
        bm.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 1;
        while (!bm.rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_seen", bm.rsp_valid, 1);
    endtask

    task automatic finish_rsp();
        bm.rsp_ready = 1'b1;
        @(negedge clk);
        bm.rsp_ready = 1'b0;
        chk("ready_after_hs", bm.req_ready, 1);
    endtask

    initial begin
        int t, t2, n;
        logic [DB-1:0] alt_data [2];
        logic [DB-1:0] bp_exp;
        alt_data[0] = 16'h5A5A;
        alt_data[1] = 16'hA5A5;
        bp_exp = BOUNDS ? 16'h0000 : 16'h07FF;

        bm.req_valid = 0; bm.req_we = 0; bm.req_addr = '0; bm.req_wdata = '0; bm.rsp_ready = 0;
        b1.req_valid = 0; b1.req_we = 0; b1.req_addr = '0; b1.req_wdata = '0; b1.rsp_ready = 0;

        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", bm.req_ready, 1);

        // load 0x00A on the RD_LAT=1 instance
        b1.req_valid = 1'b1; b1.req_we = 1'b0; b1.req_addr = 11'h00A;
        chk("l1_ready", b1.req_ready, 1);
        @(negedge clk);
        b1.req_valid = 1'b0;
        n = 1;
        while (!b1.rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("l1_latency", n, 2);
        chk("l1_rdata", b1.rsp_rdata, 16'h000A);
        b1.rsp_ready = 1'b1;
        @(negedge clk);
        b1.rsp_ready = 1'b0;
        chk("l1_ready_after_hs", b1.req_ready, 1);

        // store 0x005 <- 0xABCD
        req_m(1'b1, 11'h005, 16'hABCD, t);
        chk("st_wr_on", bm.mem_wr, 1);
        chk("st_addr", bm.mem_addr, 11'h005);
        chk("st_wdata", bm.mem_wdata, 16'hABCD);
        chk("st_busy", bm.req_ready, 0);
        @(negedge clk);
        chk("st_wr_off", bm.mem_wr, 0);
        chk("st_ready_t2", bm.req_ready, 1);
        chk("st_mem5", mem[5], 16'hABCD);

        // load 0x00A, RD_LAT=3
        req_m(1'b0, 11'h00A, 16'h0000, t);
        wait_rsp(n);
        chk("ld_latency", n, 4);
        chk("ld_rdata", bm.rsp_rdata, 16'h000A);
        finish_rsp();

        // backpressure on load 0x7FF
        req_m(1'b0, 11'h7FF, 16'h0000, t);
        wait_rsp(n);
        repeat (5) begin
            chk("bp_valid", bm.rsp_valid, 1);
            chk("bp_rdata", bm.rsp_rdata, bp_exp);
            chk("bp_ready_low", bm.req_ready, 0);
            @(negedge clk);
        end
        finish_rsp();

        // alternating store/load at 0x123
        for (int k = 0; k < 2; k++) begin
            req_m(1'b1, 11'h123, alt_data[k], t);
            req_m(1'b0, 11'h123, 16'h0000, t);
            wait_rsp(n);
            chk("alt_rdata", bm.rsp_rdata, alt_data[k]);
            finish_rsp();
        end

        // back-to-back stores
        req_m(1'b1, 11'h200, 16'h1111, t);
        req_m(1'b1, 11'h201, 16'h2222, t2);
        chk("b2b_spacing", t2 - t, 2);
        @(negedge clk);
        chk("b2b_mem201", mem[11'h201], 16'h2222);

        if (BOUNDS) begin
            req_m(1'b0, 11'h400, 16'h0000, t);
            chk("oor_ld_no_rd", bm.mem_rd, 0);
            chk("oor_ld_valid", bm.rsp_valid, 1);
            chk("oor_ld_rdata", bm.rsp_rdata, 0);
            chk("oor_ld_err", bm.rsp_err, 1);
            finish_rsp();
            chk("oor_err_clr", bm.rsp_err, 0);
            req_m(1'b1, 11'h400, 16'hBEEF, t);
            chk("oor_st_no_wr", bm.mem_wr, 0);
            @(negedge clk);
            chk("oor_st_ready", bm.req_ready, 1);
            chk("oor_st_mem", mem[11'h400], 16'h0400);
        end

        // reset in the middle of a read
        req_m(1'b0, 11'h010, 16'h0000, t);
        chk("mid_rd_on", bm.mem_rd, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_rd", bm.mem_rd, 0);
        chk("rst_async_valid", bm.rsp_valid, 0);
        chk("rst_async_ready", bm.req_ready, 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", bm.req_ready, 1);
        chk("rel_no_rsp", bm.rsp_valid, 0);
        req_m(1'b0, 11'h010, 16'h0000, t);
        wait_rsp(n);
        chk("rel_ld_rdata", bm.rsp_rdata, 16'h0010);
        finish_rsp();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end
endmodule
